// File: rtl/cpu_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PCSrc encodings, reset and
// trap vectors, bubble instruction, IF/ID field offsets and FSM/IFID-action codes.
package cpu_if_stage_pkg;

    // Next-PC select encodings driven by ID control
    localparam logic [2:0] PCSRC_SEQ    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_J      = 3'd2;
    localparam logic [2:0] PCSRC_JR     = 3'd3;
    localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
    localparam logic [2:0] PCSRC_XADR   = 3'd5;

    // Default vectors (kernel mode, bit31 set)
    localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_PC  = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_PC   = 32'h8000_0008;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    // IF/ID register layout: {Instruct, PC}
    localparam int unsigned IFID_INSTR_MSB = 63;
    localparam int unsigned IFID_PC_MSB    = 31;

    // Fetch FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // What happens to the IF/ID register this cycle
    localparam logic [1:0] IFID_HOLD   = 2'd0;
    localparam logic [1:0] IFID_BUBBLE = 2'd1;
    localparam logic [1:0] IFID_LOAD   = 2'd2;

    // Sequential increment; the kernel bit is never touched, wrap stays in bits 30:0
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/cpu_pc_next.sv
// Combinational next-PC selection for the fetch stage, with the redirect /
// stall / fetch-complete priority, plus the matching IF/ID register action.
module cpu_pc_next
    import cpu_if_stage_pkg::*;
#(
    parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
    input  logic [31:0] pc_i,
    input  logic [3:0]  ifid_pc_hi_i,
    input  logic [2:0]  pcsrc_i,
    input  logic [25:0] jt_i,
    input  logic [31:0] databus_a_i,
    input  logic        id_flush_i,
    input  logic        stall_i,
    input  logic        ex_branch_i,
    input  logic [31:0] ex_conba_i,
    input  logic        fetch_done_i,
    output logic [31:0] pc_next_o,
    output logic [1:0]  ifid_op_o,
    output logic        redirect_o
);

    logic id_redirect;

    assign id_redirect = (pcsrc_i >= PCSRC_J) && (pcsrc_i <= PCSRC_XADR);

    // Priority: EX branch, ID redirect/flush, stall, missing fetch, sequential
    always_comb begin
        pc_next_o  = pc_i;
        ifid_op_o  = IFID_HOLD;
        redirect_o = 1'b0;
        if (ex_branch_i) begin
            pc_next_o  = ex_conba_i;
            ifid_op_o  = IFID_BUBBLE;
            redirect_o = 1'b1;
        end else if (id_flush_i || id_redirect) begin
            // A flush without a jump-type PCSrc keeps the PC so the killed word is refetched
            case (pcsrc_i)
                PCSRC_J:     pc_next_o = {ifid_pc_hi_i, jt_i, 2'b00};
                PCSRC_JR:    pc_next_o = databus_a_i;
                PCSRC_ILLOP: pc_next_o = ILLOP_PC;
                PCSRC_XADR:  pc_next_o = XADR_PC;
                default:     pc_next_o = pc_i;
            endcase
            ifid_op_o  = IFID_BUBBLE;
            redirect_o = 1'b1;
        end else if (stall_i) begin
            pc_next_o = pc_i;
            ifid_op_o = IFID_HOLD;
        end else if (!fetch_done_i) begin
            pc_next_o = pc_i;
            ifid_op_o = IFID_BUBBLE;
        end else begin
            pc_next_o = pc_plus4(pc_i);
            ifid_op_o = IFID_LOAD;
        end
    end

endmodule

// File: rtl/cpu_if_stage.sv
// Instruction-fetch stage: PC register, fetch handshake FSM and IF/ID register.
// Optional performance counters are built when CPU_IF_PERF_EN is defined.
module cpu_if_stage
    import cpu_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] ILLOP_PC  = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC   = DEF_XADR_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic [25:0] JT,
    input  logic [31:0] DataBusA,
    input  logic        id_flush,
    input  logic        Stallin,
    input  logic        ex_branch,
    input  logic [31:0] ex_conba,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
`ifdef CPU_IF_PERF_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble,
`endif
    output logic [63:0] IFID
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] ifid_q, ifid_d;
    logic [1:0]  ifid_op;
    logic        redirect;
    logic        fetch_done;

    assign imem_req   = (state_q != ST_IDLE);
    assign imem_addr  = pc_q;
    assign IFID       = ifid_q;
    assign fetch_done = imem_req & imem_ready;

    cpu_pc_next #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_pc_next (
        .pc_i         (pc_q),
        .ifid_pc_hi_i (ifid_q[IFID_PC_MSB -: 4]),
        .pcsrc_i      (PCSrc),
        .jt_i         (JT),
        .databus_a_i  (DataBusA),
        .id_flush_i   (id_flush),
        .stall_i      (Stallin),
        .ex_branch_i  (ex_branch),
        .ex_conba_i   (ex_conba),
        .fetch_done_i (fetch_done),
        .pc_next_o    (pc_d),
        .ifid_op_o    (ifid_op),
        .redirect_o   (redirect)
    );

    // Fetch FSM: a redirect abandons any pending request and restarts at the new PC
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            default: state_d = (redirect || imem_ready) ? ST_FETCH : ST_WAIT;
        endcase
    end

    // IF/ID next value from the selected action
    always_comb begin
        ifid_d = ifid_q;
        case (ifid_op)
            IFID_LOAD:   ifid_d = {imem_rdata, pc_q};
            IFID_BUBBLE: ifid_d = {NOP_INSTR, 32'h0};
            default:     ifid_d = ifid_q;
        endcase
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= {NOP_INSTR, 32'h0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

`ifdef CPU_IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_bubble_q;

    assign perf_fetch  = perf_fetch_q;
    assign perf_bubble = perf_bubble_q;

    // Count words and bubbles written to IF/ID; a hold writes neither
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (ifid_op == IFID_LOAD)   perf_fetch_q  <= perf_fetch_q + 32'd1;
            if (ifid_op == IFID_BUBBLE) perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_if_stage.sv
// Self-checking bench for cpu_if_stage: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural model of the stage.
module tb_cpu_if_stage;

    logic        clk;
    logic        reset;
    logic [2:0]  PCSrc;
    logic [25:0] JT;
    logic [31:0] DataBusA;
    logic        id_flush;
    logic        Stallin;
    logic        ex_branch;
    logic [31:0] ex_conba;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [63:0] IFID;
`ifdef CPU_IF_PERF_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    cpu_if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .JT         (JT),
        .DataBusA   (DataBusA),
        .id_flush   (id_flush),
        .Stallin    (Stallin),
        .ex_branch  (ex_branch),
        .ex_conba   (ex_conba),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
`ifdef CPU_IF_PERF_EN
        .perf_fetch (perf_fetch),
        .perf_bubble(perf_bubble),
`endif
        .IFID       (IFID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    // Behavioural model: architectural PC, contents of IF/ID, whether fetching has begun
    logic [31:0] m_pc       = 32'h8000_0000;
    logic [31:0] m_ifid_ins = 32'h0;
    logic [31:0] m_ifid_pc  = 32'h0;
    bit          m_active   = 1'b0;
    logic [31:0] m_fetches  = 32'h0;
    logic [31:0] m_bubbles  = 32'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_bubble();
        m_ifid_ins = 32'h0;
        m_ifid_pc  = 32'h0;
        m_bubbles  = m_bubbles + 32'd1;
    endtask

    // Model the effect of the next rising edge given the inputs now driven
    task automatic model_step();
        bit got_word;
        got_word = m_active && imem_ready;
        if (ex_branch) begin
            m_pc = ex_conba;
            m_bubble();
        end else if (id_flush || (PCSrc >= 3'd2 && PCSrc <= 3'd5)) begin
            if (PCSrc == 3'd2)      m_pc = {m_ifid_pc[31:28], JT, 2'b00};
            else if (PCSrc == 3'd3) m_pc = DataBusA;
            else if (PCSrc == 3'd4) m_pc = 32'h8000_0004;
            else if (PCSrc == 3'd5) m_pc = 32'h8000_0008;
            m_bubble();
        end else if (Stallin) begin
            // everything holds
        end else if (!got_word) begin
            m_bubble();
        end else begin
            m_ifid_ins = imem_rdata;
            m_ifid_pc  = m_pc;
            m_pc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
            m_fetches = m_fetches + 32'd1;
        end
        m_active = 1'b1;
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_ifid_ins = 32'h0; m_ifid_pc = 32'h0;
        m_active = 1'b0; m_fetches = 32'h0; m_bubbles = 32'h0;
    endtask

    // Single compare process: every falling edge the DUT must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req",  64'(imem_req), 64'(m_active));
            check("imem_addr", 64'(imem_addr), 64'(m_pc));
            check("IFID",      IFID, {m_ifid_ins, m_ifid_pc});
`ifdef CPU_IF_PERF_EN
            check("perf_fetch",  64'(perf_fetch),  64'(m_fetches));
            check("perf_bubble", 64'(perf_bubble), 64'(m_bubbles));
`endif
        end
    end

    // Drive one cycle of inputs just after the falling edge, then advance the model
    task automatic go(input logic [2:0] ps, input logic [25:0] jt, input logic [31:0] dba,
                      input logic fl, input logic st, input logic br, input logic [31:0] cb,
                      input logic rdy, input logic [31:0] rd);
        @(negedge clk); #1;
        PCSrc = ps; JT = jt; DataBusA = dba; id_flush = fl; Stallin = st;
        ex_branch = br; ex_conba = cb; imem_ready = rdy; imem_rdata = rd;
        model_step();
    endtask

    task automatic fetch1();
        go(3'd0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000 ^ m_pc);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    // Asynchronous reset away from any edge, then release with an idle cycle
    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_req",  64'(imem_req), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h8000_0000);
        check("rst_ifid", IFID, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        PCSrc = '0; JT = '0; DataBusA = '0; id_flush = 1'b0; Stallin = 1'b0;
        ex_branch = 1'b0; ex_conba = '0; imem_ready = 1'b0; imem_rdata = '0;
        model_step();
    endtask

    logic [63:0] held;
    logic [31:0] r;

    initial begin
        reset = 1'b0;
        PCSrc = '0; JT = '0; DataBusA = '0; id_flush = 1'b0; Stallin = 1'b0;
        ex_branch = 1'b0; ex_conba = '0; imem_ready = 1'b0; imem_rdata = '0;

        do_reset();
        settle();
        check("start_addr", 64'(imem_addr), 64'h8000_0000);
        check("start_req",  64'(imem_req), 64'h1);

        go(3'd0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0000);
        settle();
        check("first_ifid", IFID, 64'h1111_0000_8000_0000);
        check("addr_04", 64'(imem_addr), 64'h8000_0004);
        fetch1();
        settle();
        check("addr_08", 64'(imem_addr), 64'h8000_0008);
        check("pin_model_pc", 64'(m_pc), 64'h8000_0008);
        fetch1(); fetch1();
        settle();
        check("addr_10", 64'(imem_addr), 64'h8000_0010);

        for (int i = 0; i < 3; i++) begin
            go(3'd0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
            settle();
            check("wait_ifid", IFID, 64'h0);
            check("wait_addr", 64'(imem_addr), 64'h8000_0010);
        end
        go(3'd0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_0010);
        settle();
        check("after_wait_ifid", IFID, 64'h2222_0010_8000_0010);
        check("after_wait_addr", 64'(imem_addr), 64'h8000_0014);

        fetch1(); fetch1(); fetch1();
        settle();
        held = IFID;
        check("pre_stall_ifid", held, 64'h40DE_001C_8000_001C);
        for (int i = 0; i < 2; i++) begin
            go(3'd0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
            settle();
            check("stall_addr", 64'(imem_addr), 64'h8000_0020);
            check("stall_ifid", IFID, 64'h40DE_001C_8000_001C);
        end
        fetch1();
        settle();
        check("resume_pc", 64'(IFID[31:0]), 64'h8000_0020);
        check("resume_addr", 64'(imem_addr), 64'h8000_0024);

        for (int i = 0; i < 8; i++) fetch1();
        settle();
        check("ifid_pc_40", 64'(IFID[31:0]), 64'h8000_0040);
        go(3'd2, 26'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_7777);
        settle();
        check("j_addr", 64'(imem_addr), 64'h8000_0040);
        check("j_ifid", IFID, 64'h0);
        go(3'd3, 26'h0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        settle();
        check("jr_addr", 64'(imem_addr), 64'h0000_1000);
        check("pin_model_jr", 64'(m_pc), 64'h0000_1000);
        go(3'd4, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        settle();
        check("illop_addr", 64'(imem_addr), 64'h8000_0004);
        go(3'd5, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        check("xadr_addr", 64'(imem_addr), 64'h8000_0008);

        go(3'd3, 26'h0, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 32'h9999_9999);
        settle();
        check("br_addr", 64'(imem_addr), 64'h0000_2000);
        check("br_ifid", IFID, 64'h0);

        go(3'd3, 26'h0, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch1();
        settle();
        check("wrap_addr", 64'(imem_addr), 64'h0000_0000);
        check("wrap_ifid_pc", 64'(IFID[31:0]), 64'h7FFF_FFFC);

        go(3'd0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        check("wait_req", 64'(imem_req), 64'h1);
        do_reset();

        // Random phase, with an occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  ps;
            logic [31:0] jtr;
            if (c % 600 == 599) begin
                do_reset();
            end else begin
                ps  = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(0, 7));
                jtr = $urandom;
                go(ps, jtr[25:0], $urandom,
                   1'($urandom_range(0, 9) == 0),
                   1'($urandom_range(0, 5) == 0),
                   1'($urandom_range(0, 11) == 0),
                   $urandom,
                   1'($urandom_range(0, 9) < 7),
                   $urandom);
            end
        end
        r = m_pc;
        settle();
        check("final_addr", 64'(imem_addr), 64'(r));

        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
